buzzer_scheduler: RTL and testbench

Sequences the 440 Hz tone generator by driving its buzzer_on and NoBuzz inputs with timed beep patterns. Three requesters share the single buzzer: key chirp (id 0), timer expiry (id 1) and alarm (id 2). Arbitration is fixed-priority, and a higher id preempts a lower one. The block sits between the application FSMs and the tone generator, on the 100 MHz system clock.

---
 rtl/buzzer_scheduler_pkg.sv | 22 ++
 rtl/buzzer_scheduler_tick_prescaler.sv | 28 ++
 rtl/buzzer_scheduler.sv | 162 ++++++++++++++++
 tb/tb_buzzer_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_scheduler_pkg.sv
// Shared state encodings, requester ids and default timing for the buzzer scheduler.
package buzzer_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam logic [1:0] ID_CHIRP = 2'd0;
  localparam logic [1:0] ID_TIMER = 2'd1;
  localparam logic [1:0] ID_ALARM = 2'd2;

  // 1 ms tick at 100 MHz; REPS of 0 means repeat until cancelled
  localparam int unsigned DEF_TICK_DIV = 100_000;
  localparam int unsigned DEF_ON_MS    = 200;
  localparam int unsigned DEF_OFF_MS   = 150;
  localparam int unsigned DEF_REPS0    = 1;
  localparam int unsigned DEF_REPS1    = 3;
  localparam int unsigned DEF_REPS2    = 0;

endpackage

// File: rtl/buzzer_scheduler_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/buzzer_scheduler.sv
// Fixed-priority beep pattern sequencer driving the 440 Hz tone generator.
// Higher ids preempt lower ones; requests seen while busy are queued in pending.
module buzzer_scheduler
  import buzzer_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned ON_MS    = DEF_ON_MS,
  parameter int unsigned OFF_MS   = DEF_OFF_MS,
  parameter int unsigned REPS0    = DEF_REPS0,
  parameter int unsigned REPS1    = DEF_REPS1,
  parameter int unsigned REPS2    = DEF_REPS2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       cancel,
  input  logic       mute,
  output logic       buzzer_on,
  output logic       no_buzz,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  localparam logic [15:0] ON_LAST  = 16'(ON_MS - 1);
  localparam logic [15:0] OFF_LAST = 16'(OFF_MS - 1);
  localparam logic [7:0]  R0       = 8'(REPS0);
  localparam logic [7:0]  R1       = 8'(REPS1);
  localparam logic [7:0]  R2       = 8'(REPS2);

  state_e      state_q, state_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [7:0]  rep_cnt_q, rep_cnt_d;
  logic [1:0]  active_id_q, active_id_d;
  logic [2:0]  pending_q, pending_d;
  logic        buzzer_on_q, no_buzz_q, busy_q, done_q, done_d;

  logic [2:0]  arb;
  logic [1:0]  grant_id;
  logic        grant_any;
  logic        start;
  logic        tick;
  logic [7:0]  reps_active;
  logic        last_rep;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .tick (tick)
  );

  assign arb       = pending_q | req;
  assign grant_any = |arb;

  always_comb begin
    grant_id = ID_CHIRP;
    if (arb[ID_ALARM]) begin
      grant_id = ID_ALARM;
    end else if (arb[ID_TIMER]) begin
      grant_id = ID_TIMER;
    end
  end

  always_comb begin
    reps_active = R2;
    case (active_id_q)
      ID_CHIRP: reps_active = R0;
      ID_TIMER: reps_active = R1;
      default:  reps_active = R2;
    endcase
  end

  assign last_rep = (reps_active != 8'd0) && (rep_cnt_q == reps_active - 8'd1);

  always_comb begin
    state_d     = state_q;
    ms_cnt_d    = ms_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    active_id_d = active_id_q;
    pending_d   = pending_q | req;
    done_d      = 1'b0;
    start       = 1'b0;

    if (cancel) begin
      // cancel also swallows any req arriving in the same cycle
      state_d   = IDLE;
      pending_d = 3'b000;
    end else begin
      case (state_q)
        IDLE:    start = grant_any;
        ON, OFF: start = grant_any && (grant_id > active_id_q);
        default: start = 1'b0;
      endcase

      if (start) begin
        state_d             = ON;
        ms_cnt_d            = 16'd0;
        rep_cnt_d           = 8'd0;
        active_id_d         = grant_id;
        pending_d[grant_id] = 1'b0;
      end else if (tick) begin
        case (state_q)
          ON: begin
            if (ms_cnt_q == ON_LAST) begin
              ms_cnt_d = 16'd0;
              if (last_rep) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = OFF;
              end
            end else begin
              ms_cnt_d = ms_cnt_q + 16'd1;
            end
          end
          OFF: begin
            if (ms_cnt_q == OFF_LAST) begin
              ms_cnt_d  = 16'd0;
              rep_cnt_d = rep_cnt_q + 8'd1;
              state_d   = ON;
            end else begin
              ms_cnt_d = ms_cnt_q + 16'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ms_cnt_q    <= 16'd0;
      rep_cnt_q   <= 8'd0;
      active_id_q <= 2'd0;
      pending_q   <= 3'b000;
      buzzer_on_q <= 1'b0;
      no_buzz_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      active_id_q <= active_id_d;
      pending_q   <= pending_d;
      buzzer_on_q <= (state_d == ON);
      no_buzz_q   <= mute;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
    end
  end

  assign buzzer_on = buzzer_on_q;
  assign no_buzz   = no_buzz_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with short timing (TICK_DIV=4, ON_MS=2, OFF_MS=1).
module tb_buzzer_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       cancel;
  logic       mute;
  logic       buzzer_on;
  logic       no_buzz;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  int tests = 0;
  int fails = 0;

  // per-cycle capture, bit c = cycle c after the initial request (cycle 0)
  logic [63:0] bon_v, dn_v, bsy_v, nb_v;
  logic [1:0]  aid [0:63];

  always #5 clk = ~clk;

  buzzer_scheduler #(
    .TICK_DIV (4),
    .ON_MS    (2),
    .OFF_MS   (1),
    .REPS0    (1),
    .REPS1    (3),
    .REPS2    (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cancel    (cancel),
    .mute      (mute),
    .buzzer_on (buzzer_on),
    .no_buzz   (no_buzz),
    .busy      (busy),
    .active_id (active_id),
    .done      (done)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] r0, input int inj_c, input logic [2:0] inj_r,
                     input int can_c, input logic [2:0] can_r,
                     input int m_on, input int m_off, input int n);
    bon_v = '0; dn_v = '0; bsy_v = '0; nb_v = '0;
    for (int c = 0; c <= n; c++) begin
      bon_v[c] = buzzer_on;
      dn_v[c]  = done;
      bsy_v[c] = busy;
      nb_v[c]  = no_buzz;
      aid[c]   = active_id;
      if (c == 0)          req = r0;
      else if (c == inj_c) req = inj_r;
      else if (c == can_c) req = can_r;
      else                 req = 3'b000;
      cancel = (c == can_c);
      mute   = (c >= m_on) && (c < m_off);
      next_cycle();
    end
    req = 3'b000; cancel = 1'b0; mute = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; cancel = 1'b0; mute = 1'b0;
    repeat (3) next_cycle();
    tests++;
    if ({buzzer_on, no_buzz, busy, active_id, done} !== 6'b010000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b",
               {buzzer_on, no_buzz, busy, active_id, done}, 6'b010000);
    end
    rst = 1'b0;
    repeat (2) next_cycle();
  endtask

  task automatic test_chirp();
    run(3'b001, -1, 3'b000, -1, 3'b000, 0, 0, 12);
    tests++;
    if (bon_v !== 64'h1FE) begin
      fails++; $display("FAIL chirp_buzzer: got %h expected %h", bon_v, 64'h1FE);
    end
    tests++;
    if (dn_v !== 64'h200) begin
      fails++; $display("FAIL chirp_done: got %h expected %h", dn_v, 64'h200);
    end
    tests++;
    if (bsy_v !== 64'h1FE) begin
      fails++; $display("FAIL chirp_busy: got %h expected %h", bsy_v, 64'h1FE);
    end
    tests++;
    if (aid[1] !== 2'd0) begin
      fails++; $display("FAIL chirp_id: got %0d expected 0", aid[1]);
    end
  endtask

  task automatic test_timer();
    run(3'b010, -1, 3'b000, -1, 3'b000, 0, 0, 40);
    tests++;
    if (bon_v !== 64'h1_FE1F_E1FE) begin
      fails++; $display("FAIL timer_buzzer: got %h expected %h", bon_v, 64'h1_FE1F_E1FE);
    end
    tests++;
    if (dn_v !== 64'h2_0000_0000) begin
      fails++; $display("FAIL timer_done: got %h expected %h", dn_v, 64'h2_0000_0000);
    end
    tests++;
    if (bsy_v !== 64'h1_FFFF_FFFE) begin
      fails++; $display("FAIL timer_busy: got %h expected %h", bsy_v, 64'h1_FFFF_FFFE);
    end
    tests++;
    if (aid[1] !== 2'd1) begin
      fails++; $display("FAIL timer_id: got %0d expected 1", aid[1]);
    end
    tests++;
    if (aid[40] !== 2'd1) begin
      fails++; $display("FAIL timer_id_hold_idle: got %0d expected 1", aid[40]);
    end
  endtask

  task automatic test_back_to_back();
    run(3'b011, -1, 3'b000, -1, 3'b000, 0, 0, 50);
    tests++;
    if (bon_v !== 64'h3FD_FE1F_E1FE) begin
      fails++; $display("FAIL b2b_buzzer: got %h expected %h", bon_v, 64'h3FD_FE1F_E1FE);
    end
    tests++;
    if (dn_v !== 64'h402_0000_0000) begin
      fails++; $display("FAIL b2b_done: got %h expected %h", dn_v, 64'h402_0000_0000);
    end
    tests++;
    if (bsy_v !== 64'h3FD_FFFF_FFFE) begin
      fails++; $display("FAIL b2b_busy: got %h expected %h", bsy_v, 64'h3FD_FFFF_FFFE);
    end
    tests++;
    if (aid[1] !== 2'd1) begin
      fails++; $display("FAIL b2b_first_id: got %0d expected 1", aid[1]);
    end
    tests++;
    if (aid[34] !== 2'd0) begin
      fails++; $display("FAIL b2b_second_id: got %0d expected 0", aid[34]);
    end
  endtask

  // timer preempted by alarm in its first OFF gap; alarm cancelled mid-beep
  // together with a chirp request that must be discarded
  task automatic test_preempt_cancel();
    run(3'b010, 10, 3'b100, 40, 3'b001, 0, 0, 48);
    tests++;
    if (bon_v !== 64'h1F8_7F87_F9FE) begin
      fails++; $display("FAIL preempt_buzzer: got %h expected %h", bon_v, 64'h1F8_7F87_F9FE);
    end
    tests++;
    if (dn_v !== 64'h0) begin
      fails++; $display("FAIL preempt_done: got %h expected %h", dn_v, 64'h0);
    end
    tests++;
    if (bsy_v !== 64'h1FF_FFFF_FFFE) begin
      fails++; $display("FAIL preempt_busy: got %h expected %h", bsy_v, 64'h1FF_FFFF_FFFE);
    end
    tests++;
    if (aid[10] !== 2'd1 || aid[11] !== 2'd2) begin
      fails++; $display("FAIL preempt_id: got %0d,%0d expected 1,2", aid[10], aid[11]);
    end
  endtask

  task automatic test_mute();
    run(3'b010, -1, 3'b000, -1, 3'b000, 0, 36, 40);
    tests++;
    if (nb_v !== 64'h1F_FFFF_FFFE) begin
      fails++; $display("FAIL mute_no_buzz: got %h expected %h", nb_v, 64'h1F_FFFF_FFFE);
    end
    tests++;
    if (bon_v !== 64'h1_FE1F_E1FE) begin
      fails++; $display("FAIL mute_buzzer: got %h expected %h", bon_v, 64'h1_FE1F_E1FE);
    end
  endtask

  task automatic test_reset_mid();
    int busy_seen;
    req = 3'b010; next_cycle();
    req = 3'b000; next_cycle();
    req = 3'b001; next_cycle();
    req = 3'b000; next_cycle();
    tests++;
    if ({buzzer_on, active_id} !== 3'b101) begin
      fails++; $display("FAIL rstmid_pre: got %b expected %b", {buzzer_on, active_id}, 3'b101);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({buzzer_on, no_buzz, busy, active_id, done} !== 6'b010000) begin
      fails++;
      $display("FAIL rstmid_async: got %b expected %b",
               {buzzer_on, no_buzz, busy, active_id, done}, 6'b010000);
    end
    next_cycle();
    rst = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      if (busy || buzzer_on) busy_seen++;
    end
    tests++;
    if (busy_seen !== 0) begin
      fails++; $display("FAIL rstmid_pending_cleared: busy cycles %0d expected 0", busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_chirp();
    test_timer();
    test_back_to_back();
    test_preempt_cancel();
    test_mute();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
